e1ofn_sync_receiver: RTL
========================

Name: e1ofn_sync_receiver

Overview:
- Clocked receiving end of the e1ofN_M delay-insensitive channel (N-rail one-hot digits x M, with enable acknowledge); the synchronous counterpart to a CSP/QDI sender.
- Synchronizes the data rails, detects completion, decodes them to binary and buffers the word in a small FIFO with a valid/ready output.
- Drives the channel enable through the full four-phase handshake, so the RTL side of the cosim wrapper needs no hand-written enable logic.

Parameters:
- N, 2, rails per digit; power of 2, at least 2.
- M, 4, digits per word.
- SYNC_STAGES, 2, flops per rail in the synchronizer; at least 2.
- DEPTH, 2, FIFO entries; power of 2, at least 2.
- W (local), M*$clog2(N), output data width.

Ports:
- CLK  in  1  clock.
- _RESET  in  1  reset, asynchronous, active-low.
- in_d  in  N*M  channel rails; digit i occupies in_d[i*N +: N].
- in_e  out  1  channel enable/acknowledge; 1 = ready for data.
- out_data  out  W  decoded word at the FIFO head.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer accepts; pop occurs when out_valid & out_ready.
- count  out  $clog2(DEPTH)+1  FIFO occupancy.
- err_illegal  out  1  sticky flag: some digit had two or more hot rails.

Behaviour:
- Reset (async assert, sync release): in_e=0, out_valid=0, count=0, out_data=0, err_illegal=0, FIFO pointers cleared, state=WAIT_NEUTRAL.
- Synchronizer: every rail passes through SYNC_STAGES flops; all control uses the synced rails (sd) only.
- Digit status: valid when exactly one rail is hot; neutral when zero rails are hot; illegal when two or more rails are hot.
- all_valid: every digit valid. all_neutral: every rail low. any_illegal: at least one digit illegal.
- Decode: out_data[i*log2N +: log2N] = index of the hot rail of digit i. For N=2, rail 1 means bit 1.
- FSM, WAIT_VALID (in_e=1):
  - all_valid & !any_illegal & count<DEPTH: push the decoded word, in_e<=0, go to WAIT_NEUTRAL.
  - all_valid & count==DEPTH: hold, in_e stays 1, no push (backpressure).
  - otherwise: stay.
- FSM, WAIT_NEUTRAL (in_e=0): when all_neutral, set in_e<=1 and go to WAIT_VALID.
- err_illegal: set on any cycle with any_illegal, in either state. It clears only on reset. An illegal word is never pushed.
- Latency, SYNC_STAGES=2, rails stable before edge k:
  - push: in_e falls and out_valid rises (from empty) at edge k+2.
  - release: rails neutral before edge j gives in_e rising at edge j+2.
- Full-throughput bound: one word per 2*(SYNC_STAGES+1) cycles plus sender delay.
- Push test uses the registered count only; there is no pop-bypass when full.
- Simultaneous push and pop (0<count<DEPTH): count unchanged, order preserved.
- Pop from empty never occurs, because out_valid=0.
- Pointers wrap modulo DEPTH; count ranges 0..DEPTH.
- out_data shows the head entry; when the FIFO is empty it holds its last value.
- Reset mid-handshake: in_e goes to 0 immediately and the FIFO is flushed. After release the FSM stays in WAIT_NEUTRAL until the rails go neutral, so a word still on the rails is never double-captured.

Decomposition:
- Package e1ofn_pkg:
  - state enum {WAIT_VALID, WAIT_NEUTRAL};
  - function digit_status(N-bit) returning {NEUTRAL, VALID, ILLEGAL};
  - function digit_index(N-bit) returning the log2N index.
- Sub-module e1ofn_rail_sync: parameterized N*M-bit multi-stage synchronizer with async active-low reset to 0.
- FSM, decode and FIFO are inline in e1ofn_sync_receiver.

Test Plan:
- Single word: rails for value 5 (N=2: digits 1,0,1,0 LSB first), out_ready=1 -> out_data=5 and out_valid=1 at edge k+2, in_e=0. After rails go neutral, in_e=1 two edges later.
- Backpressure: send 1..6 with out_ready=0 -> count=2 and in_e stays 1 with word 3 on the rails. Raise out_ready -> outputs 1,2,3,4,5,6 in order, no loss or duplicate.
- Illegal code: digit 0 rails = 2'b11 with other digits valid -> err_illegal=1, count unchanged, in_e stays 1. err_illegal stays 1 after the rails go neutral, until reset.
- Reset mid-handshake: capture value 9 (in_e=0), assert _RESET with rails still 9 -> out_valid=0, count=0, in_e=0. Release: in_e stays 0 until rails neutral, then 1, and nothing is pushed.
- Simultaneous push/pop: count=1 (value 3), pop on the same edge as the push of value 7 -> count=1, out_data=7.
- Random cosim: 200 random words from the CSP sender -> received sequence identical, err_illegal=0.

Source files
------------

// File: rtl/e1ofn_pkg.sv
// e1ofn_pkg: shared types and per-digit helpers for the e1ofN receiver
package e1ofn_pkg;
  localparam int NMAX = 64;
  localparam int IW = $clog2(NMAX);
  typedef enum logic {WAIT_VALID, WAIT_NEUTRAL} state_t;
  typedef enum logic [1:0] {NEUTRAL, VALID, ILLEGAL} dstat_t;
  function automatic dstat_t digit_status(input logic [NMAX-1:0] d);
    int c;
    c = 0;
    for (int k = 0; k < NMAX; k++) c += int'(d[k]);
    return (c == 0) ? NEUTRAL : (c == 1) ? VALID : ILLEGAL;
  endfunction
  function automatic logic [IW-1:0] digit_index(input logic [NMAX-1:0] d);
    logic [IW-1:0] r;
    r = '0;
    for (int k = 0; k < NMAX; k++) if (d[k]) r = IW'(k);
    return r;
  endfunction
endpackage

// File: rtl/e1ofn_rail_sync.sv
// e1ofn_rail_sync: STAGES-deep flop synchronizer per rail, async active-low reset to 0
// Ports: i_clk, i_rst_n, i_d (async rails), o_q (synced rails)
module e1ofn_rail_sync #(
  parameter int WIDTH = 8,
  parameter int STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH-1:0] r_s [STAGES];
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      for (int k = 0; k < STAGES; k++) r_s[k] <= '0;
    end else begin
      r_s[0] <= i_d;
      for (int k = 1; k < STAGES; k++) r_s[k] <= r_s[k-1];
    end
  assign o_q = r_s[STAGES-1];
endmodule

// File: rtl/e1ofn_sync_receiver.sv
// e1ofn_sync_receiver: clocked e1ofN_M channel receiver with decode, FIFO and four-phase enable
// Ports: CLK/_RESET; in_d rails, in_e enable; out_data/out_valid/out_ready stream; count occupancy; err_illegal sticky
module e1ofn_sync_receiver
  import e1ofn_pkg::*;
#(
  parameter int N = 2,
  parameter int M = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DEPTH = 2,
  localparam int LG = $clog2(N),
  localparam int W = M * LG,
  localparam int CW = $clog2(DEPTH) + 1,
  localparam int PW = $clog2(DEPTH),
  localparam int WW = $clog2(SYNC_STAGES + 1)
) (
  input  logic           CLK,
  input  logic           _RESET,
  input  logic [N*M-1:0] in_d,
  output logic           in_e,
  output logic [W-1:0]   out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [CW-1:0]  count,
  output logic           err_illegal
);
  logic [N*M-1:0] w_sd;
  logic [M-1:0]   w_dvalid, w_dill;
  logic [W-1:0]   w_dec;
  logic           w_all_valid, w_all_neutral, w_any_ill, w_push, w_pop;
  state_t         r_state;
  logic           r_in_e, r_err;
  logic [WW-1:0]  r_warm;
  logic [W-1:0]   r_mem [DEPTH];
  logic [W-1:0]   r_last;
  logic [PW-1:0]  r_rd, r_wr;
  logic [CW-1:0]  r_count;
  e1ofn_rail_sync #(.WIDTH(N*M), .STAGES(SYNC_STAGES)) u_sync (
    .i_clk  (CLK),
    .i_rst_n(_RESET),
    .i_d    (in_d),
    .o_q    (w_sd)
  );
  for (genvar i = 0; i < M; i++) begin : g_dig
    assign w_dvalid[i] = digit_status(NMAX'(w_sd[i*N +: N])) == VALID;
    assign w_dill[i] = digit_status(NMAX'(w_sd[i*N +: N])) == ILLEGAL;
    assign w_dec[i*LG +: LG] = LG'(digit_index(NMAX'(w_sd[i*N +: N])));
  end
  assign w_all_valid = &w_dvalid;
  assign w_all_neutral = ~|w_sd;
  assign w_any_ill = |w_dill;
  assign w_push = (r_state == WAIT_VALID) && w_all_valid && !w_any_ill && (r_count != CW'(DEPTH));
  assign w_pop = out_valid && out_ready;
  // r_warm holds off the neutral test until the synchronizer has refilled after reset,
  // so a word still on the rails is not mistaken for neutral and captured twice.
  always_ff @(posedge CLK or negedge _RESET)
    if (!_RESET) begin
      r_state <= WAIT_NEUTRAL;
      r_in_e <= 1'b0;
      r_err <= 1'b0;
      r_warm <= '0;
    end else begin
      if (r_warm != WW'(SYNC_STAGES)) r_warm <= r_warm + WW'(1);
      if (w_any_ill) r_err <= 1'b1;
      if (r_state == WAIT_VALID) begin
        if (w_push) begin
          r_in_e <= 1'b0;
          r_state <= WAIT_NEUTRAL;
        end
      end else if (w_all_neutral && r_warm == WW'(SYNC_STAGES)) begin
        r_in_e <= 1'b1;
        r_state <= WAIT_VALID;
      end
    end
  always_ff @(posedge CLK or negedge _RESET)
    if (!_RESET) begin
      r_rd <= '0;
      r_wr <= '0;
      r_count <= '0;
      r_last <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + PW'(1);
      if (w_pop) begin
        r_rd <= r_rd + PW'(1);
        r_last <= r_mem[r_rd];
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  always_ff @(posedge CLK)
    if (w_push) r_mem[r_wr] <= w_dec;
  assign in_e = r_in_e;
  assign out_valid = r_count != '0;
  assign out_data = out_valid ? r_mem[r_rd] : r_last;
  assign count = r_count;
  assign err_illegal = r_err;
endmodule
